// File: rtl/sha_uart_pkg.sv
// Shared types and helpers for the digest-to-UART streaming path.
package sha_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FIN
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Lowercase hex digit: 0-9 -> '0'-'9', 10-15 -> 'a'-'f'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else return 8'h57 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/hex_ascii_enc.sv
// Combinational encoder: picks one nibble of a byte and returns its ASCII hex char.
module hex_ascii_enc
  import sha_uart_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       sel_hi,
  output logic [7:0] ascii
);

  assign ascii = nibble_to_ascii(sel_hi ? byte_in[7:4] : byte_in[3:0]);

endmodule

// File: rtl/digest_uart_streamer.sv
// Captures one digest per handshake and streams it as raw bytes or ASCII hex,
// optionally CR/LF terminated, through a uart_tx style byte interface.
module digest_uart_streamer
  import sha_uart_pkg::*;
#(
  parameter int DIGEST_W    = 256,
  parameter int HEX_MODE    = 0,
  parameter int MSB_FIRST   = 1,
  parameter int APPEND_CRLF = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                digest_valid,
  output logic                digest_ready,
  input  logic [DIGEST_W-1:0] digest,
  output logic                tx_dv,
  output logic [7:0]          tx_byte,
  input  logic                tx_active,
  input  logic                tx_done,
  output logic                busy,
  output logic                done
);

  localparam int NBYTES   = DIGEST_W / 8;
  localparam int NPAYLOAD = NBYTES * ((HEX_MODE != 0) ? 2 : 1);
  localparam int NCHARS   = NPAYLOAD + ((APPEND_CRLF != 0) ? 2 : 0);
  localparam int IW       = $clog2(NCHARS + 1);

  localparam logic [IW-1:0] LAST_CHAR   = IW'(NCHARS - 1);
  localparam logic [IW-1:0] PAYLOAD_END = IW'(NPAYLOAD);
  localparam logic [IW-1:0] LAST_BYTE   = IW'(NBYTES - 1);

  state_t              state;
  logic [DIGEST_W-1:0] dig_q;
  logic [IW-1:0]       char_idx;
  logic [IW-1:0]       pos;
  logic [IW-1:0]       byte_idx;
  logic [7:0]          sel_byte;
  logic [7:0]          payload_char;
  logic [7:0]          next_char;

  // Two hex chars share one payload byte, so the byte position is char_idx/2.
  assign pos      = (HEX_MODE != 0) ? (char_idx >> 1) : char_idx;
  assign byte_idx = (MSB_FIRST != 0) ? (LAST_BYTE - pos) : pos;

  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (byte_idx == IW'(i)) sel_byte = dig_q[i*8 +: 8];
    end
  end

  generate
    if (HEX_MODE != 0) begin : g_hex
      hex_ascii_enc u_enc (
        .byte_in (sel_byte),
        .sel_hi  (~char_idx[0]),
        .ascii   (payload_char)
      );
    end else begin : g_raw
      assign payload_char = sel_byte;
    end
  endgenerate

  always_comb begin
    next_char = payload_char;
    if ((APPEND_CRLF != 0) && (char_idx >= PAYLOAD_END))
      next_char = (char_idx == PAYLOAD_END) ? ASCII_CR : ASCII_LF;
  end

  // Handshake: a digest transfers on a clk edge where digest_valid && digest_ready;
  // digest_ready is registered and only high in IDLE, so nothing queues mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dig_q        <= '0;
      char_idx     <= '0;
      digest_ready <= 1'b0;
      tx_dv        <= 1'b0;
      tx_byte      <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      tx_dv <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          digest_ready <= 1'b1;
          if (digest_valid && digest_ready) begin
            dig_q        <= digest;
            char_idx     <= '0;
            digest_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (!tx_active) begin
            tx_byte <= next_char;
            tx_dv   <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            if (char_idx == LAST_CHAR) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              char_idx <= char_idx + IW'(1);
              state    <= ISSUE;
            end
          end
        end
        FIN: begin
          busy         <= 1'b0;
          digest_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digest_uart_streamer.sv
// Bench for digest_uart_streamer: three parameter sets, each with its own UART
// model, expected-char queue built from the digest, and frame-level checks.
module tb_digest_uart_streamer;

  localparam logic [255:0] HELLO =
    256'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9;

  logic clk = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   fin [3];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar G = 0; G < 3; G++) begin : g_cfg
    localparam int W  = (G == 2) ? 16 : 256;
    localparam int HX = (G == 1) ? 1 : 0;
    localparam int MF = (G == 2) ? 0 : 1;
    localparam int CL = (G == 1) ? 1 : 0;
    localparam int NB = W / 8;

    logic         rst_n = 1'b0;
    logic         digest_valid = 1'b0;
    logic [W-1:0] digest = '0;
    logic         digest_ready, tx_dv, busy, done;
    logic [7:0]   tx_byte;
    logic         tx_active, tx_done;
    logic         hold_active = 1'b0, s_done = 1'b0;
    logic         m_active = 1'b0, m_done = 1'b0, last_mdone = 1'b0, prev_dv = 1'b0;
    bit           rnd_dly = 1'b0;
    int           cnt = 0, n_dv = 0, n_done = 0;
    logic [7:0]   exp_q[$];
    logic [7:0]   seen_q[$];
    logic [7:0]   e;

    assign tx_active = m_active | hold_active;
    assign tx_done   = m_done | s_done;

    digest_uart_streamer #(
      .DIGEST_W(W), .HEX_MODE(HX), .MSB_FIRST(MF), .APPEND_CRLF(CL)
    ) dut (
      .clk(clk), .rst_n(rst_n), .digest_valid(digest_valid), .digest_ready(digest_ready),
      .digest(digest), .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active),
      .tx_done(tx_done), .busy(busy), .done(done)
    );

    // Monitor first, then the UART model advances for the next cycle.
    always @(negedge clk) begin
      if (tx_dv) begin
        n_dv++;
        seen_q.push_back(tx_byte);
        check($sformatf("c%0d_dv_width", G), prev_dv, 1'b0);
        check($sformatf("c%0d_busy_on_dv", G), busy, 1'b1);
        check($sformatf("c%0d_char_expected", G), exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("c%0d_char%0d", G, n_dv), tx_byte, e);
        end
      end
      if (done) begin
        n_done++;
        check($sformatf("c%0d_done_all_sent", G), exp_q.size(), 0);
        check($sformatf("c%0d_done_after_txdone", G), last_mdone, 1'b1);
      end
      prev_dv = tx_dv;
      m_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          m_done   = 1'b1;
          m_active = 1'b0;
        end
      end
      if (tx_dv) begin
        m_active = 1'b1;
        cnt = rnd_dly ? int'($urandom_range(1, 12)) : 10;
      end
      last_mdone = m_done;
    end

    function automatic logic [W-1:0] rand_digest();
      logic [W-1:0] d;
      for (int i = 0; i < NB; i++) d[i*8 +: 8] = 8'($urandom_range(0, 255));
      return d;
    endfunction

    // Expected stream: bytes in send order, then formatted as text when hex.
    function automatic void push_model(input logic [W-1:0] d);
      logic [7:0] b;
      string s;
      for (int i = 0; i < NB; i++) begin
        b = d[((MF != 0) ? (NB - 1 - i) : i) * 8 +: 8];
        if (HX != 0) begin
          s = $sformatf("%02x", b);
          exp_q.push_back(s[0]);
          exp_q.push_back(s[1]);
        end else begin
          exp_q.push_back(b);
        end
      end
      if (CL != 0) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
    endfunction

    task automatic init_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check($sformatf("c%0d_rst_ready", G), digest_ready, 1'b0);
      check($sformatf("c%0d_rst_dv", G), tx_dv, 1'b0);
      check($sformatf("c%0d_rst_byte", G), tx_byte, 8'h00);
      check($sformatf("c%0d_rst_busy", G), busy, 1'b0);
      check($sformatf("c%0d_rst_done", G), done, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check($sformatf("c%0d_ready_after_rst", G), digest_ready, 1'b1);
    endtask

    task automatic wait_ready();
      bit got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
        if (digest_ready) got = 1'b1;
        else @(negedge clk);
      end
      check($sformatf("c%0d_ready_timeout", G), got, 1'b1);
    endtask

    task automatic idle_spur();
      s_done = 1'b1;
      @(negedge clk);
      s_done = 1'b0;
      @(negedge clk);
      check($sformatf("c%0d_idle_spur_busy", G), busy, 1'b0);
      check($sformatf("c%0d_idle_spur_dv", G), tx_dv, 1'b0);
      check($sformatf("c%0d_idle_spur_ready", G), digest_ready, 1'b1);
    endtask

    // mode 0: plain, 1: tx_active held 20 cycles with a stray tx_done, 2: new valid mid-frame
    task automatic send_frame(input logic [W-1:0] d, input int mode);
      int nd0;
      bit got;
      wait_ready();
      push_model(d);
      seen_q.delete();
      nd0 = n_done;
      if (mode == 1) hold_active = 1'b1;
      digest = d;
      digest_valid = 1'b1;
      @(negedge clk);
      digest_valid = 1'b0;
      digest = rand_digest();
      check($sformatf("c%0d_ready_fall", G), digest_ready, 1'b0);
      check($sformatf("c%0d_busy_rise", G), busy, 1'b1);
      if (mode == 1) begin
        for (int i = 0; i < 20; i++) begin
          s_done = (i == 5);
          @(negedge clk);
          check($sformatf("c%0d_hold_no_dv", G), tx_dv, 1'b0);
        end
        s_done = 1'b0;
        hold_active = 1'b0;
        @(negedge clk);
        check($sformatf("c%0d_dv_after_release", G), tx_dv, 1'b1);
      end else begin
        @(negedge clk);
        check($sformatf("c%0d_first_dv_cycle2", G), tx_dv, 1'b1);
        if (mode == 2) begin
          digest_valid = 1'b1;
          digest = ~d;
          for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check($sformatf("c%0d_midframe_ready", G), digest_ready, 1'b0);
          end
          digest_valid = 1'b0;
        end
      end
      got = 1'b0;
      for (int i = 0; i < 4000 && !got; i++) begin
        if (done) got = 1'b1;
        else @(negedge clk);
      end
      check($sformatf("c%0d_done_timeout", G), got, 1'b1);
      @(negedge clk);
      check($sformatf("c%0d_done_pulse", G), done, 1'b0);
      check($sformatf("c%0d_ready_back", G), digest_ready, 1'b1);
      check($sformatf("c%0d_busy_fall", G), busy, 1'b0);
      check($sformatf("c%0d_done_count", G), n_done, nd0 + 1);
    endtask

    task automatic reset_mid(input logic [W-1:0] d);
      int nd0, target;
      bit got;
      wait_ready();
      push_model(d);
      nd0 = n_done;
      target = n_dv + 6;
      digest = d;
      digest_valid = 1'b1;
      @(negedge clk);
      digest_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
        @(negedge clk);
        if (n_dv >= target) got = 1'b1;
      end
      check($sformatf("c%0d_reach_char5", G), got, 1'b1);
      rst_n = 1'b0;
      #1;
      check($sformatf("c%0d_midrst_dv", G), tx_dv, 1'b0);
      check($sformatf("c%0d_midrst_busy", G), busy, 1'b0);
      check($sformatf("c%0d_midrst_done", G), done, 1'b0);
      check($sformatf("c%0d_midrst_ready", G), digest_ready, 1'b0);
      repeat (2) @(negedge clk);
      exp_q.delete();
      rst_n = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clk);
        if (!m_active) got = 1'b1;
      end
      check($sformatf("c%0d_uart_drain", G), got, 1'b1);
      @(negedge clk);
      check($sformatf("c%0d_midrst_ready_back", G), digest_ready, 1'b1);
      check($sformatf("c%0d_midrst_no_done", G), n_done, nd0);
    endtask

    if (G == 0) begin : g_seq
      initial begin
        init_reset();
        idle_spur();
        send_frame(HELLO, 0);
        check("c0_hello_count", seen_q.size(), 32);
        check("c0_hello_first", seen_q[0], 8'hB9);
        check("c0_hello_last", seen_q[31], 8'hE9);
        send_frame(rand_digest(), 1);
        send_frame(rand_digest(), 2);
        reset_mid(rand_digest());
        send_frame(HELLO, 0);
        check("c0_after_rst_first", seen_q[0], 8'hB9);
        rnd_dly = 1'b1;
        repeat (3) send_frame(rand_digest(), 0);
        fin[G] = 1'b1;
      end
    end else if (G == 1) begin : g_seq
      initial begin
        init_reset();
        send_frame(HELLO, 0);
        check("c1_hex_count", seen_q.size(), 66);
        check("c1_hex_c0", seen_q[0], 8'h62);
        check("c1_hex_c1", seen_q[1], 8'h39);
        check("c1_hex_c2", seen_q[2], 8'h34);
        check("c1_hex_c63", seen_q[63], 8'h39);
        check("c1_hex_cr", seen_q[64], 8'h0D);
        check("c1_hex_lf", seen_q[65], 8'h0A);
        rnd_dly = 1'b1;
        repeat (3) send_frame(rand_digest(), 0);
        fin[G] = 1'b1;
      end
    end else begin : g_seq
      initial begin
        init_reset();
        send_frame(16'hA55A, 0);
        check("c2_lsb_count", seen_q.size(), 2);
        check("c2_lsb_b0", seen_q[0], 8'h5A);
        check("c2_lsb_b1", seen_q[1], 8'hA5);
        idle_spur();
        rnd_dly = 1'b1;
        repeat (6) send_frame(rand_digest(), 0);
        fin[G] = 1'b1;
      end
    end
  end

  initial begin
    bit all_fin;
    all_fin = 1'b0;
    for (int i = 0; i < 60000 && !all_fin; i++) begin
      @(negedge clk);
      all_fin = fin[0] && fin[1] && fin[2];
    end
    n_cmp++;
    if (!all_fin) begin
      n_err++;
      $display("FAIL global_timeout: finished %0d%0d%0d, required 111", fin[0], fin[1], fin[2]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
